// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the instruction-fetch and load/store ports.
// Optional: define ARB_MISALIGN_CHK_EN to reject misaligned data accesses with d_err instead of masking addr[1:0].
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_err,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned LW = 3;
  localparam int unsigned SW = 4;
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic is_data;
    logic we;
  } owner_t;

  state_t          state_q, state_d;
  owner_t          own_q, own_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic            if_valid_q, if_valid_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            d_valid_q, d_valid_d;
  logic            d_err_q, d_err_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            misalign_c;
  logic            grant_data_c;

`ifdef ARB_MISALIGN_CHK_EN
  assign misalign_c = (d_addr[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Data wins unless fetch has waited through STARVE_MAX consecutive data grants.
  assign grant_data_c = d_req & ~(if_req & (starve_q == SW'(STARVE_MAX)));

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_valid_d   = 1'b0;
    d_err_d     = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_data_c) begin
          own_d = '{is_data: 1'b1, we: d_we};
          if (if_req) begin
            starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
          if (misalign_c) begin
            // Rejected access: answer immediately without touching memory or d_rdata.
            state_d   = RESP;
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr & WORD_MASK;
            mem_wdata_d = d_wdata;
          end
        end else if (if_req) begin
          own_d      = '{is_data: 1'b0, we: 1'b0};
          starve_d   = '0;
          state_d    = ISSUE;
          mem_req_d  = 1'b1;
          mem_be_d   = 4'hF;
          mem_addr_d = if_addr & WORD_MASK;
        end
      end

      ISSUE: begin
        if (own_q.we) begin
          state_d   = RESP;
          d_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
          lat_d   = LW'(RD_LAT - 1);
        end
      end

      WAIT: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (own_q.is_data) begin
            d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      own_q       <= '0;
      lat_q       <= '0;
      starve_q    <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign stall = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1, one with RD_LAT=3, sharing requester inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata_a, mem_rdata_b;

  logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a;
  logic        if_valid_a, d_valid_a, d_err_a, stall_a, mem_req_a, mem_we_a;
  logic [3:0]  mem_be_a;
  logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;
  logic        if_valid_b, d_valid_b, d_err_b, stall_b, mem_req_b, mem_we_b;
  logic [3:0]  mem_be_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_a), .if_valid(if_valid_a),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_a), .d_valid(d_valid_a), .d_err(d_err_a), .stall(stall_a),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_be(mem_be_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_b), .if_valid(if_valid_b),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_b), .d_valid(d_valid_b), .d_err(d_err_b), .stall(stall_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_be(mem_be_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] got [10];
    logic [31:0] exp_g [10];
    int          ng;
    logic        seen;

    reset       = 1'b0;
    if_req      = 1'b0;
    if_addr     = '0;
    d_req       = 1'b0;
    d_we        = 1'b0;
    d_be        = '0;
    d_addr      = '0;
    d_wdata     = '0;
    mem_rdata_a = 32'hBAD0_0001;
    mem_rdata_b = 32'hBAD0_0003;

    // Reset state
    idle(2);
    check("rst_mem_req",  32'(mem_req_a),  32'h0);
    check("rst_mem_addr", mem_addr_a,      32'h0);
    check("rst_if_valid", 32'(if_valid_a), 32'h0);
    check("rst_d_valid",  32'(d_valid_a),  32'h0);
    check("rst_d_err",    32'(d_err_a),    32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Fetch read, RD_LAT=1
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    #1 check("t1_stall_T0", 32'(stall_a), 32'h1);
    @(negedge clk);
    check("t1_mem_req",  32'(mem_req_a), 32'h1);
    check("t1_mem_addr", mem_addr_a,     32'h0000_0100);
    check("t1_mem_we",   32'(mem_we_a),  32'h0);
    check("t1_mem_be",   32'(mem_be_a),  32'hF);
    check("t1_stall_T1", 32'(stall_a),   32'h1);
    @(negedge clk);
    check("t1_if_valid_T2", 32'(if_valid_a), 32'h0);
    check("t1_stall_T2",    32'(stall_a),    32'h1);
    mem_rdata_a = 32'h0050_0093;
    @(negedge clk);
    check("t1_if_valid_T3", 32'(if_valid_a), 32'h1);
    check("t1_if_rdata",    if_rdata_a,      32'h0050_0093);
    check("t1_stall_T3",    32'(stall_a),    32'h0);
    if_req      = 1'b0;
    mem_rdata_a = 32'hBAD0_0001;
    idle(8);

    // Data store
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'h3;
    d_addr  = 32'h0000_2004;
    d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t2_mem_req",   32'(mem_req_a), 32'h1);
    check("t2_mem_we",    32'(mem_we_a),  32'h1);
    check("t2_mem_be",    32'(mem_be_a),  32'h3);
    check("t2_mem_addr",  mem_addr_a,     32'h0000_2004);
    check("t2_mem_wdata", mem_wdata_a,    32'hDEAD_BEEF);
    check("t2_d_valid_T1", 32'(d_valid_a), 32'h0);
    @(negedge clk);
    check("t2_d_valid_T2", 32'(d_valid_a),  32'h1);
    check("t2_if_valid",   32'(if_valid_a), 32'h0);
    check("t2_mem_req_T2", 32'(mem_req_a),  32'h0);
    check("t2_mem_we_T2",  32'(mem_we_a),   32'h0);
    check("t2_addr_hold",  mem_addr_a,      32'h0000_2004);
    d_req = 1'b0;
    d_we  = 1'b0;
    idle(8);

    // Both requesters held: starvation counter forces every fifth grant to fetch
    if_addr = 32'h0000_0300;
    d_addr  = 32'h0000_0400;
    d_we    = 1'b0;
    d_be    = 4'hF;
    if_req  = 1'b1;
    d_req   = 1'b1;
    exp_g = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300,
              32'h400, 32'h400, 32'h400, 32'h400, 32'h300};
    for (int i = 0; i < 10; i++) got[i] = '0;
    ng = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      @(negedge clk);
      if (mem_req_a) begin
        got[ng] = mem_addr_a;
        ng++;
      end
    end
    check("t3_grant_count", 32'(ng), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("t3_grant%0d", i), got[i], exp_g[i]);
    if_req = 1'b0;
    d_req  = 1'b0;
    idle(14);

    // Load with RD_LAT=3
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_be   = 4'hF;
    d_addr = 32'h0000_0040;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("t4_mem_req_T1",  32'(mem_req_b), 32'h1);
        check("t4_mem_addr_T1", mem_addr_b,      32'h0000_0040);
      end else if (k < 5) begin
        check($sformatf("t4_mem_req_T%0d", k), 32'(mem_req_b), 32'h0);
        check($sformatf("t4_d_valid_T%0d", k), 32'(d_valid_b), 32'h0);
      end else begin
        check("t4_d_valid_T5", 32'(d_valid_b), 32'h1);
        check("t4_d_rdata",    d_rdata_b,      32'h1111_0004);
        d_req = 1'b0;
      end
      mem_rdata_b = 32'h1111_0000 + 32'(k);
    end
    idle(10);

    // Reset in the middle of a RD_LAT=3 read
    d_req  = 1'b1;
    d_addr = 32'h0000_0080;
    @(negedge clk);
    check("t5_mem_req_T1", 32'(mem_req_b), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_mem_req",   32'(mem_req_b),  32'h0);
    check("t5_mem_addr",  mem_addr_b,      32'h0);
    check("t5_mem_be",    32'(mem_be_b),   32'h0);
    check("t5_mem_wdata", mem_wdata_b,     32'h0);
    check("t5_d_rdata",   d_rdata_b,       32'h0);
    check("t5_if_rdata",  if_rdata_b,      32'h0);
    check("t5_d_valid",   32'(d_valid_b),  32'h0);
    check("t5_a_d_rdata", d_rdata_a,       32'h0);
    d_req = 1'b0;
    @(negedge clk);
    reset       = 1'b1;
    mem_rdata_b = 32'hFEED_F00D;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (d_valid_b || if_valid_b || mem_req_b || (d_rdata_b != 32'h0)) seen = 1'b1;
    end
    check("t5_no_resp_after_reset", 32'(seen), 32'h0);

    // Misaligned load
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_be   = 4'hF;
    d_addr = 32'h0000_1002;
    @(negedge clk);
`ifdef ARB_MISALIGN_CHK_EN
    check("t6_mem_req", 32'(mem_req_a), 32'h0);
    check("t6_d_valid", 32'(d_valid_a), 32'h1);
    check("t6_d_err",   32'(d_err_a),   32'h1);
    check("t6_d_rdata", d_rdata_a,      32'h0);
    d_req = 1'b0;
`else
    check("t6_mem_req",  32'(mem_req_a), 32'h1);
    check("t6_mem_addr", mem_addr_a,     32'h0000_1000);
    @(negedge clk);
    check("t6_d_valid_T2", 32'(d_valid_a), 32'h0);
    mem_rdata_a = 32'h5555_AAAA;
    @(negedge clk);
    check("t6_d_valid_T3", 32'(d_valid_a), 32'h1);
    check("t6_d_err",      32'(d_err_a),   32'h0);
    check("t6_d_rdata",    d_rdata_a,      32'h5555_AAAA);
    d_req = 1'b0;
`endif
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port. Sits between riscv_core and the unified SRAM. Provides a per-request valid handshake and a combined stall to the core. Data accesses take priority; an anti-starvation counter guarantees fetch progress.

Parameters:
AW, 32, address width.
DW, 32, data width; must be 32.
RD_LAT, 1, memory read latency in cycles from the mem_req cycle to mem_rdata valid; legal range 1..7.
STARVE_MAX, 4, maximum consecutive data grants while if_req is pending before fetch is forced; legal range 1..15.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
if_req  in  1  fetch request; held until if_valid.
if_addr  in  AW  fetch address; stable while if_req.
if_rdata  out  DW  fetched word.
if_valid  out  1  one-cycle pulse; if_rdata is valid.
d_req  in  1  data request; held until d_valid.
d_we  in  1  1 = store, 0 = load.
d_be  in  4  store byte enables.
d_addr  in  AW  data address.
d_wdata  in  DW  store data.
d_rdata  out  DW  load data.
d_valid  out  1  one-cycle pulse; load data valid or store acknowledged.
d_err  out  1  misalignment error, qualified by d_valid; see Optional Feature.
stall  out  1  (if_req & ~if_valid) | (d_req & ~d_valid); combinational.
mem_req  out  1  memory access strobe; one cycle per access.
mem_we  out  1  write strobe; qualified by mem_req.
mem_be  out  4  byte enables.
mem_addr  out  AW  word address; bits [1:0] are always 0.
mem_wdata  out  DW  write data.
mem_rdata  in  DW  read data, valid RD_LAT cycles after mem_req.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE. Counters clear.
  - All outputs are 0: if_rdata, d_rdata, valids, d_err, mem_* outputs.
  - Any in-flight read is discarded. mem_rdata returning after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs except stall are registered.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise arbitrate, latch owner, addr, we, be and wdata, then go to ISSUE.
- Arbitration (IDLE only):
  - d_req alone: grant data.
  - if_req alone: grant fetch.
  - Both pending: grant data, unless starve_cnt == STARVE_MAX; then grant fetch.
  - starve_cnt increments on each data grant made while if_req=1.
  - starve_cnt clears on any fetch grant, or on a data grant made while if_req=0.
  - starve_cnt saturates at STARVE_MAX.
- ISSUE (exactly one cycle):
  - mem_req=1 and mem_addr={addr[AW-1:2],2'b00}.
  - Fetch: mem_be=4'hF, mem_we=0.
  - Data: mem_be=d_be, mem_we=d_we, mem_wdata=d_wdata.
  - Next state: a write goes to RESP. A read loads lat_cnt=RD_LAT-1 and goes to WAIT.
- WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt==0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP (exactly one cycle):
  - Owner's valid=1. d_err=0 unless set by the misalignment check.
  - Next state is IDLE. Requests are not sampled in RESP; requesters use this cycle to drop or change req.
- Latency, request seen at cycle T in IDLE:
  - Read: mem_req at T+1, valid at T+2+RD_LAT.
  - Write: mem_req at T+1, d_valid at T+2.
- Outside ISSUE, mem_req and mem_we are 0; mem_addr, mem_be and mem_wdata hold their last values.
- Between responses, if_rdata and d_rdata hold their last captured value.
- Requester drops req mid-transaction: the access still completes and valid still pulses. Arbitration is unaffected.
- Requester changes addr mid-transaction: has no effect; the latched values are used.

Optional Feature:
Macro ARB_MISALIGN_CHK_EN.
- Defined:
  - A data grant with d_addr[1:0]!=0 skips ISSUE and WAIT and goes directly to RESP.
  - In that RESP: d_valid=1, d_err=1, d_rdata unchanged, and no mem_req is generated.
  - Fetches are never checked.
- Not defined:
  - d_err is tied 0.
  - Address bits [1:0] are silently cleared and the access proceeds normally.

Test Plan:
1. Reset low, then high at cycle 2; if_req=1 with if_addr=0x100 seen at T. Required: mem_req=1 and mem_addr=0x100 at T+1. With RD_LAT=1 and mem_rdata=0x00500093 at T+2, if_valid=1 and if_rdata=0x00500093 at T+3; stall=1 during T..T+2 and 0 at T+3.
2. d_req=1, d_we=1, d_be=4'h3, d_addr=0x2004, d_wdata=0xDEAD_BEEF. Required: at T+1, mem_req=mem_we=1, mem_be=3, mem_addr=0x2004, mem_wdata=0xDEADBEEF; d_valid=1 at T+2; if_valid stays 0.
3. if_req and d_req both held continuously with reads, STARVE_MAX=4. Required grant order: D, D, D, D, F, D, D, D, D, F.
4. RD_LAT=3, load at 0x40 requested at T. Required: mem_req only at T+1; d_valid at T+5 with d_rdata equal to mem_rdata sampled at T+4.
5. Reset asserted at T+2 during a RD_LAT=3 read. Required: all outputs are 0 immediately; after release there is no valid pulse and mem_rdata is ignored.
6. With ARB_MISALIGN_CHK_EN, load at d_addr=0x1002. Required: no mem_req; d_valid=d_err=1 at T+1. Without the macro: mem_addr=0x1000 and d_err=0.
